// File: rtl/split_arbiter_2.sv
// Round-robin scheduler sharing one 2-way split stage among N_REQ requesters.
// Captures the winner's payload, drives both branches, collects both frees (or times out), then frees the requester.
module split_arbiter_2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              i_drive,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_data,
    output logic [N_REQ-1:0]              o_free,
    output logic                          o_driveNext0,
    output logic                          o_driveNext1,
    output logic [DATA_WIDTH-1:0]         o_data0,
    output logic [DATA_WIDTH-1:0]         o_data1,
    input  logic                          i_freeNext0,
    input  logic                          i_freeNext1,
    output logic [$clog2(N_REQ)-1:0]      o_grant_id,
    output logic                          o_busy,
    output logic                          o_timeout,
    output logic [7:0]                    o_err_cnt,
    output logic [N_REQ-1:0]              o_overrun
);

    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_REL   = 4'b1000
    } state_e;

    state_e                  state_q, state_d;
    logic [N_REQ-1:0]        pending_q, pending_d;
    logic [N_REQ-1:0]        overrun_q, overrun_d;
    logic [N_REQ-1:0]        free_q, free_d;
    logic [N_REQ-1:0]        rel_vec;
    logic                    f0_q, f0_d, f1_q, f1_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_q, last_d;
    logic [GW-1:0]           pick, idx;
    logic                    pick_vld;
    logic                    timeout_q, timeout_d;
    logic [7:0]              err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    drive_q, drive_d;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = GW'((32'(last_q) + i) % N_REQ);
            if (!pick_vld && pending_q[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        rel_vec = '0;
        if (state_q == S_REL) rel_vec[grant_q] = 1'b1;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        data_d    = data_q;
        f0_d      = f0_q;
        f1_d      = f1_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        // A new drive in the release cycle wins over the clear
        pending_d = (pending_q & ~rel_vec) | i_drive;
        overrun_d = overrun_q | (i_drive & pending_q & ~rel_vec);

        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        if (pick == GW'(k)) data_d = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                f0_d    = 1'b0;
                f1_d    = 1'b0;
                timer_d = TW'(TIMEOUT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                f0_d    = f0_q | i_freeNext0;
                f1_d    = f1_q | i_freeNext1;
                timer_d = timer_q - TW'(1);
                if (f0_d && f1_d) begin
                    state_d = S_REL;
                end else if ((TIMEOUT != 0) && (timer_q == TW'(1))) begin
                    state_d   = S_REL;
                    timeout_d = 1'b1;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            S_REL: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        drive_d = (state_d == S_ISSUE);
        free_d  = '0;
        if (state_d == S_REL) free_d[grant_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            free_q    <= '0;
            f0_q      <= 1'b0;
            f1_q      <= 1'b0;
            timer_q   <= '0;
            data_q    <= '0;
            grant_q   <= '0;
            last_q    <= GW'(N_REQ - 1);
            timeout_q <= 1'b0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            drive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            free_q    <= free_d;
            f0_q      <= f0_d;
            f1_q      <= f1_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            drive_q   <= drive_d;
        end
    end

    assign o_free       = free_q;
    assign o_driveNext0 = drive_q;
    assign o_driveNext1 = drive_q;
    assign o_data0      = data_q;
    assign o_data1      = data_q;
    assign o_grant_id   = grant_q;
    assign o_busy       = busy_q;
    assign o_timeout    = timeout_q;
    assign o_err_cnt    = err_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_split_arbiter_2.sv
// Directed self-checking bench for split_arbiter_2 (TIMEOUT=8 instance).
module tb_split_arbiter_2;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        i_drive;
    logic [NR*DW-1:0]     i_data;
    logic [NR-1:0]        o_free;
    logic                 o_driveNext0, o_driveNext1;
    logic [DW-1:0]        o_data0, o_data1;
    logic                 i_freeNext0, i_freeNext1;
    logic [1:0]           o_grant_id;
    logic                 o_busy, o_timeout;
    logic [7:0]           o_err_cnt;
    logic [NR-1:0]        o_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    split_arbiter_2 #(.DATA_WIDTH(DW), .N_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
        .o_driveNext0(o_driveNext0), .o_driveNext1(o_driveNext1),
        .o_data0(o_data0), .o_data1(o_data1),
        .i_freeNext0(i_freeNext0), .i_freeNext1(i_freeNext1),
        .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout(o_timeout),
        .o_err_cnt(o_err_cnt), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [DW-1:0] v);
        i_data[k*DW +: DW] = v;
    endtask

    task automatic frees(input logic b0, input logic b1);
        i_freeNext0 = b0;
        i_freeNext1 = b1;
    endtask

    // From an IDLE cycle with requester g pending: issue, prompt frees, release
    task automatic serve(input int g, input logic [DW-1:0] d);
        logic [NR-1:0] m;
        m = '0;
        m[g] = 1'b1;
        tick();
        chk("rr_drive0", 64'(o_driveNext0), 64'd1);
        chk("rr_drive1", 64'(o_driveNext1), 64'd1);
        chk("rr_grant", 64'(o_grant_id), 64'(g));
        chk("rr_data0", 64'(o_data0), 64'(d));
        chk("rr_data1", 64'(o_data1), 64'(d));
        tick();
        frees(1'b1, 1'b1);
        tick();
        chk("rr_free", 64'(o_free), 64'(m));
        frees(1'b0, 1'b0);
        tick();
        chk("rr_idle_busy", 64'(o_busy), 64'd0);
    endtask

    // Full transaction with no frees at all: watchdog releases after TO WAIT cycles
    task automatic timeout_txn(input int g);
        logic [NR-1:0] m;
        m = '0;
        m[g] = 1'b1;
        i_drive = m;
        tick();
        i_drive = '0;
        tick();
        tick();
        repeat (TO - 1) tick();
        tick();
        chk("wd_free", 64'(o_free), 64'(m));
        tick();
    endtask

    initial begin
        rst = 1'b0;
        i_drive = '0;
        i_data = '0;
        frees(1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_free", 64'(o_free), 64'd0);
        chk("rst_drive", 64'({o_driveNext0, o_driveNext1}), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_grant", 64'(o_grant_id), 64'd0);
        chk("rst_err", 64'({o_timeout, o_err_cnt, o_overrun}), 64'd0);
        rst = 1'b1;

        // Single request from 2
        set_data(2, 32'hDEADBEEF);
        i_drive = 4'b0100;
        tick();
        i_drive = '0;
        chk("t1_idle_busy", 64'(o_busy), 64'd0);
        tick();
        chk("t1_drive0", 64'(o_driveNext0), 64'd1);
        chk("t1_drive1", 64'(o_driveNext1), 64'd1);
        chk("t1_data0", 64'(o_data0), 64'hDEADBEEF);
        chk("t1_data1", 64'(o_data1), 64'hDEADBEEF);
        chk("t1_grant", 64'(o_grant_id), 64'd2);
        chk("t1_busy", 64'(o_busy), 64'd1);
        tick();
        chk("t1_drive_pulse", 64'(o_driveNext0), 64'd0);
        tick();
        tick();
        frees(1'b1, 1'b1);
        tick();
        chk("t1_free", 64'(o_free), 64'b0100);
        frees(1'b0, 1'b0);
        tick();
        chk("t1_free_pulse", 64'(o_free), 64'd0);
        chk("t1_busy_fall", 64'(o_busy), 64'd0);
        chk("t1_timeout", 64'(o_timeout), 64'd0);
        chk("t1_data_hold", 64'(o_data0), 64'hDEADBEEF);

        // Round-robin from a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < int'(NR); k++) set_data(k, DW'(k));
        i_drive = 4'b1111;
        tick();
        i_drive = '0;
        serve(0, 32'd0);
        serve(1, 32'd1);
        serve(2, 32'd2);
        serve(3, 32'd3);
        i_drive = 4'b0011;
        tick();
        i_drive = '0;
        serve(0, 32'd0);
        serve(1, 32'd1);
        i_drive = 4'b1001;
        tick();
        i_drive = '0;
        serve(3, 32'd3);
        serve(0, 32'd0);

        // Split frees; free during ISSUE is ignored
        set_data(2, 32'hA5A50F0F);
        i_drive = 4'b0100;
        tick();
        i_drive = '0;
        tick();
        chk("t3_grant", 64'(o_grant_id), 64'd2);
        frees(1'b0, 1'b1);
        tick();
        frees(1'b1, 1'b0);
        tick();
        chk("t3_c2_free", 64'(o_free), 64'd0);
        frees(1'b0, 1'b0);
        tick();
        chk("t3_c3_free", 64'(o_free), 64'd0);
        chk("t3_c3_busy", 64'(o_busy), 64'd1);
        tick();
        chk("t3_c4_free", 64'(o_free), 64'd0);
        tick();
        chk("t3_c5_free", 64'(o_free), 64'd0);
        frees(1'b0, 1'b1);
        tick();
        chk("t3_free", 64'(o_free), 64'b0100);
        chk("t3_timeout", 64'(o_timeout), 64'd0);
        frees(1'b0, 1'b0);
        tick();
        chk("t3_busy_fall", 64'(o_busy), 64'd0);

        // Watchdog with only branch 0 freeing
        i_drive = 4'b0001;
        tick();
        i_drive = '0;
        tick();
        chk("t4_grant", 64'(o_grant_id), 64'd0);
        tick();
        frees(1'b1, 1'b0);
        tick();
        frees(1'b0, 1'b0);
        repeat (6) tick();
        chk("t4_c8_free", 64'(o_free), 64'd0);
        chk("t4_c8_timeout", 64'(o_timeout), 64'd0);
        tick();
        chk("t4_free", 64'(o_free), 64'b0001);
        chk("t4_timeout", 64'(o_timeout), 64'd1);
        chk("t4_err1", 64'(o_err_cnt), 64'd1);
        tick();
        chk("t4_idle", 64'(o_busy), 64'd0);
        frees(1'b0, 1'b1);
        tick();
        frees(1'b0, 1'b0);
        chk("t4_late_busy", 64'(o_busy), 64'd0);
        chk("t4_late_free", 64'(o_free), 64'd0);
        chk("t4_late_err", 64'(o_err_cnt), 64'd1);

        // Error counter saturation
        repeat (253) timeout_txn(3);
        chk("t4_err254", 64'(o_err_cnt), 64'd254);
        timeout_txn(3);
        chk("t4_err255", 64'(o_err_cnt), 64'd255);
        timeout_txn(3);
        chk("t4_err_sat", 64'(o_err_cnt), 64'd255);
        chk("t4_timeout_sticky", 64'(o_timeout), 64'd1);

        // Overrun: second drive while pending gives one transaction
        i_drive = 4'b0010;
        tick();
        i_drive = '0;
        tick();
        chk("t5_grant", 64'(o_grant_id), 64'd1);
        i_drive = 4'b0010;
        tick();
        i_drive = '0;
        chk("t5_overrun", 64'(o_overrun), 64'b0010);
        frees(1'b1, 1'b1);
        tick();
        chk("t5_free", 64'(o_free), 64'b0010);
        frees(1'b0, 1'b0);
        tick();
        chk("t5_idle", 64'(o_busy), 64'd0);
        tick();
        chk("t5_single_txn", 64'(o_busy), 64'd0);
        tick();
        chk("t5_no_drive", 64'(o_driveNext0), 64'd0);

        // Drive coinciding with release starts a second transaction
        i_drive = 4'b0010;
        tick();
        i_drive = '0;
        tick();
        tick();
        frees(1'b1, 1'b1);
        tick();
        chk("t5_co_free", 64'(o_free), 64'b0010);
        i_drive = 4'b0010;
        frees(1'b0, 1'b0);
        tick();
        i_drive = 4'b0001;
        tick();
        i_drive = '0;
        chk("t5_second_drive", 64'(o_driveNext0), 64'd1);
        chk("t5_second_grant", 64'(o_grant_id), 64'd1);
        tick();

        // Async reset in WAIT
        rst = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(o_busy), 64'd0);
        chk("t5_rst_grant", 64'(o_grant_id), 64'd0);
        chk("t5_rst_data", 64'({o_data0, o_data1}), 64'd0);
        chk("t5_rst_flags", 64'({o_timeout, o_err_cnt, o_overrun}), 64'd0);
        chk("t5_rst_pulses", 64'({o_free, o_driveNext0, o_driveNext1}), 64'd0);
        tick();
        tick();
        chk("t5_rst_free", 64'(o_free), 64'd0);
        rst = 1'b1;
        i_drive = 4'b1000;
        tick();
        i_drive = '0;
        tick();
        chk("t5_post_drive", 64'(o_driveNext0), 64'd1);
        chk("t5_post_grant", 64'(o_grant_id), 64'd3);
        chk("t5_post_data", 64'(o_data0), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
